// File: rtl/hilo_mdu_pkg.sv
// Shared types and sizing for the hilo_mdu iterative multiply/divide unit.
// Holds the op encoding, the FSM state encoding and the default operand width.
package hilo_mdu_pkg;

   localparam int MDU_WIDTH = 32;

   function automatic int mdu_cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

   typedef enum logic [1:0] {
      MDU_MULTU = 2'b00,
      MDU_MULT  = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/hilo_mdu_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// The divide half exists only when HILO_MDU_DIV_EN is defined.
module hilo_mdu_step
   import hilo_mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   input  logic             is_div,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo,
   output logic             q_bit
);

   logic [WIDTH:0] sum;

   // The carry out of the add becomes the top bit after the right shift.
   assign sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {WIDTH{1'b0}})};

`ifdef HILO_MDU_DIV_EN
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   assign trial = {acc_hi, acc_lo[WIDTH-1]};
   assign diff  = trial - {1'b0, operand};

   always_comb begin
      if (is_div) begin
         // A borrow out of the subtract means the divisor did not fit: restore.
         q_bit   = ~diff[WIDTH];
         next_hi = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
         q_bit   = 1'b0;
         next_hi = sum[WIDTH:1];
         next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end
`else
   always_comb begin
      q_bit   = 1'b0;
      next_hi = is_div ? acc_hi : sum[WIDTH:1];
      next_lo = is_div ? acc_lo : {sum[0], acc_lo[WIDTH-1:1]};
   end
`endif

endmodule

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding its result in HI/LO; 33-cycle latency at 32 bits.
// Define HILO_MDU_DIV_EN to build the divider; without it divides complete with HI=LO=0.
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int               CNT_W     = mdu_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mdu_state_e       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic             sign_a, sign_b, div_op;
`ifdef HILO_MDU_DIV_EN
   logic [WIDTH-1:0] a_raw;
`endif

   logic             is_signed, is_div, start_sa, start_sb;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign is_signed = (Op == MDU_MULT) || (Op == MDU_DIV);
   assign is_div    = (Op == MDU_DIVU) || (Op == MDU_DIV);
   assign start_sa  = is_signed & A[WIDTH-1];
   assign start_sb  = is_signed & B[WIDTH-1];
   assign mag_a     = start_sa ? -A : A;
   assign mag_b     = start_sb ? -B : B;

   logic [WIDTH-1:0] step_hi, step_lo;
   logic             step_q;

   hilo_mdu_step #(.WIDTH(WIDTH)) u_step (
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (opnd),
      .is_div  (div_op),
      .next_hi (step_hi),
      .next_lo (step_lo),
      .q_bit   (step_q)
   );

   logic [2*WIDTH-1:0] prod, prod_signed;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic               fix_dz;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      prod        = {acc_hi, acc_lo};
      prod_signed = (sign_a ^ sign_b) ? -prod : prod;
      fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
      fix_lo      = prod_signed[WIDTH-1:0];
      fix_dz      = 1'b0;
      if (div_op) begin
`ifdef HILO_MDU_DIV_EN
         // The divisor magnitude is still in opnd, so a zero divisor is detected here.
         if (opnd == '0) begin
            fix_hi = a_raw;
            fix_lo = '1;
            fix_dz = 1'b1;
         end else begin
            fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            fix_hi = sign_a ? -acc_hi : acc_hi;
         end
`else
         fix_hi = '0;
         fix_lo = '0;
`endif
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_IDLE;
         count   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         div_op  <= 1'b0;
`ifdef HILO_MDU_DIV_EN
         a_raw   <= '0;
`endif
         Busy    <= 1'b0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state   <= ST_RUN;
                  count   <= '0;
                  acc_hi  <= '0;
                  acc_lo  <= is_div ? mag_a : mag_b;
                  opnd    <= is_div ? mag_b : mag_a;
                  sign_a  <= start_sa;
                  sign_b  <= start_sb;
                  div_op  <= is_div;
`ifdef HILO_MDU_DIV_EN
                  a_raw   <= A;
`endif
                  Busy    <= 1'b1;
                  DivZero <= 1'b0;
               end
            end
            ST_RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo | {{(WIDTH-1){1'b0}}, step_q};
               count  <= count + 1'b1;
               if (count == LAST_ITER) state <= ST_FIX;
            end
            ST_FIX: begin
               Hi      <= fix_hi;
               Lo      <= fix_lo;
               DivZero <= fix_dz;
               Done    <= 1'b1;
               Busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: transaction-level reference model plus directed literal cases.
// Follows HILO_MDU_DIV_EN the same way the design does.
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Start = 1'b0;
   logic [1:0]    Op = 2'b00;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          Busy, Done, DivZero;
   logic [W-1:0]  Hi, Lo;

   hilo_mdu #(.WIDTH(W)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .Hi      (Hi),
      .Lo      (Lo)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } res_t;

   // Architectural result of one operation, straight from the instruction definitions.
   function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t        r;
      logic [63:0] p;
      longint      pa, pb;
      int          sa, sb;
      r = '0;
      case (op)
         2'b00: begin
            p = {32'b0, a} * {32'b0, b};
            {r.hi, r.lo} = p;
         end
         2'b01: begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            {r.hi, r.lo} = p;
         end
         default: begin
`ifdef HILO_MDU_DIV_EN
            if (b == '0) begin
               r.hi = a;
               r.lo = '1;
               r.dz = 1'b1;
            end else if (op == 2'b10) begin
               r.lo = a / b;
               r.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.lo = 32'h8000_0000;
               r.hi = '0;
            end else begin
               sa = a;
               sb = b;
               r.lo = 32'(sa / sb);
               r.hi = 32'(sa % sb);
            end
`else
            r = '0;
`endif
         end
      endcase
      return r;
   endfunction

   // Reference: an accepted op yields its result 33 edges after the accepting edge.
   logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           m_cnt = 0;
   res_t         m_pend = '0;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (Start) begin
               m_busy <= 1'b1;
               m_cnt  <= 0;
               m_dz   <= 1'b0;
               m_pend <= model(Op, A, B);
            end
         end else if (m_cnt == W) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_hi   <= m_pend.hi;
            m_lo   <= m_pend.lo;
            m_dz   <= m_pend.dz;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         check("busy", Busy, m_busy);
         check("done", Done, m_done);
         check("divzero", DivZero, m_dz);
         check("hi", Hi, m_hi);
         check("lo", Lo, m_lo);
      end
   end

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Issue one op while idle (or in its Done cycle); optionally re-assert Start at cycle poke_at.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_at, output int lat);
      Op = op; A = a; B = b; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      Op = 2'($urandom); A = W'($urandom); B = W'($urandom);
      check("busy_after_start", Busy, 1'b1);
      check("divzero_cleared", DivZero, 1'b0);
      lat = 0;
      while (lat < 40 && !Done) begin
         Start = (lat == poke_at);
         if (Start) begin
            Op = 2'b00; A = 32'h0000_0005; B = 32'h0000_0009;
         end
         @(posedge Clk); #1;
         lat++;
      end
      Start = 1'b0;
      if (!Done) check("done_timeout", Done, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int done_seen;
      int gap;
      logic [1:0] rop;

      repeat (3) @(posedge Clk);
      #1;
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_divzero", DivZero, 1'b0);
      check("rst_hi", Hi, 32'h0);
      check("rst_lo", Lo, 32'h0);
      Reset_n = 1'b1;
      cmp_en  = 1'b1;
      @(posedge Clk); #1;

      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat);
      check("multu_latency", lat, 33);
      check("multu_hi", Hi, 32'hFFFF_FFFE);
      check("multu_lo", Lo, 32'h0000_0001);

      run_op(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 10, lat);
      check("mult_poke_latency", lat, 33);
      check("mult_hi", Hi, 32'hFFFF_FFFF);
      check("mult_lo", Lo, 32'hFFFF_FFEB);

      // Abort a MULT at cycle 20 with an asynchronous reset pulse.
      Op = MDU_MULT; A = 32'h0000_1234; B = 32'hFFFF_0001; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (19) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      check("abort_busy", Busy, 1'b0);
      check("abort_done", Done, 1'b0);
      check("abort_hi", Hi, 32'h0);
      check("abort_lo", Lo, 32'h0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge Clk); #1;
         if (Done) done_seen++;
      end
      check("no_done_after_abort", done_seen, 0);

      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1, lat);
`ifdef HILO_MDU_DIV_EN
      check("div_lo", Lo, 32'hFFFF_FFFD);
      check("div_hi", Hi, 32'hFFFF_FFFF);
`else
      check("div_lo", Lo, 32'h0);
      check("div_hi", Hi, 32'h0);
`endif
      run_op(MDU_DIVU, 32'd100, 32'd7, -1, lat);
      check("divu_latency", lat, 33);
`ifdef HILO_MDU_DIV_EN
      check("divu_lo", Lo, 32'd14);
      check("divu_hi", Hi, 32'd2);
`else
      check("divu_lo", Lo, 32'h0);
      check("divu_hi", Hi, 32'h0);
`endif

      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
`ifdef HILO_MDU_DIV_EN
      check("div_ovf_lo", Lo, 32'h8000_0000);
`else
      check("div_ovf_lo", Lo, 32'h0);
`endif
      check("div_ovf_hi", Hi, 32'h0);
      check("div_ovf_flag", DivZero, 1'b0);

      run_op(MDU_DIVU, 32'h0000_1234, 32'h0, -1, lat);
      check("dz_latency", lat, 33);
`ifdef HILO_MDU_DIV_EN
      check("dz_lo", Lo, 32'hFFFF_FFFF);
      check("dz_hi", Hi, 32'h0000_1234);
      check("dz_flag", DivZero, 1'b1);
`else
      check("dz_lo", Lo, 32'h0);
      check("dz_hi", Hi, 32'h0);
      check("dz_flag", DivZero, 1'b0);
`endif

      run_op(MDU_MULTU, 32'd6, 32'd7, -1, lat);
      check("multu_small_lo", Lo, 32'd42);
      check("multu_small_hi", Hi, 32'd0);

      for (int i = 0; i < 60; i++) begin
         rop = 2'($urandom_range(0, 3));
         run_op(rop, pick(), pick(), -1, lat);
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge Clk); #1;
         end
      end

      repeat (3) @(posedge Clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
